ifetch_responder: RTL and testbench

//  Instruction-side responder for the fetch stage. Takes the fetch PC and returns the

---
 rtl/ifetch_pkg.sv | 29 ++
 rtl/ifetch_line_store.sv | 53 +++++
 rtl/ifetch_responder.sv | 137 +++++++++++++
 tb/tb_ifetch_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and address-split helpers for the instruction-fetch responder.
// Helpers take the field widths as arguments so any parameterisation can use them.
package ifetch_pkg;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  localparam int ADDR_W_DEF = 16;
  localparam int LINES_DEF  = 16;
  localparam int WPL_DEF    = 4;

  localparam int OFF_W = $clog2(WPL_DEF);
  localparam int IDX_W = $clog2(LINES_DEF);
  localparam int TAG_W = ADDR_W_DEF - 2 - OFF_W - IDX_W;

  function automatic logic [31:0] get_off(input logic [31:0] pc, input int off_w);
    return (pc >> 2) & ((32'd1 << off_w) - 32'd1);
  endfunction

  function automatic logic [31:0] get_idx(input logic [31:0] pc, input int off_w,
                                          input int idx_w);
    return (pc >> (2 + off_w)) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] get_tag(input logic [31:0] pc, input int off_w,
                                          input int idx_w, input int addr_w);
    return (pc >> (2 + off_w + idx_w)) & ((32'd1 << (addr_w - 2 - off_w - idx_w)) - 32'd1);
  endfunction

endpackage

// File: rtl/ifetch_line_store.sv
// Direct-mapped line storage: valid bits (reset/flushable), tags and data words.
// Tag and data arrays carry no reset; only the valid bits define line ownership.
module ifetch_line_store #(
  parameter int LINES = 16,
  parameter int WPL   = 4,
  parameter int IDX_W = 4,
  parameter int OFF_W = 2,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [OFF_W-1:0] rd_off,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [31:0]      wr_data,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [TAG_W-1:0] set_tag,
  input  logic             flush_all
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES][WPL];

  // Flush dominates a same-cycle set so a flushed fill never leaves a live line.
  always_ff @(posedge clk) begin
    if (reset || flush_all) begin
      r_valid <= '0;
    end else if (set_en) begin
      r_valid[set_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_data[wr_idx][wr_off] <= wr_data;
    end
    if (set_en) begin
      r_tag[set_idx] <= set_tag;
    end
  end

  assign rd_valid = r_valid[rd_idx];
  assign rd_tag   = r_tag[rd_idx];
  assign rd_data  = r_data[rd_idx][rd_off];

endmodule

// File: rtl/ifetch_responder.sv
// Fetch-side instruction responder: combinational lookup into a direct-mapped line
// buffer, stall on miss, and whole-line refill over a req/gnt + rvalid burst.
module ifetch_responder
  import ifetch_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int LINES          = LINES_DEF,
  parameter int WORDS_PER_LINE = WPL_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc_in,
  input  logic              flush,
  output logic [31:0]       inst_out,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_W - 2 - OW - IW;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << (OW + 2)) - 1);
  localparam logic [OW-1:0]     LAST_BEAT = OW'(WORDS_PER_LINE - 1);

  state_t            r_state;
  logic [OW-1:0]     r_beat;
  logic              r_flush_pend;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] r_addr;

  logic [IW-1:0]     w_idx;
  logic [OW-1:0]     w_off;
  logic [TW-1:0]     w_tag;
  logic [IW-1:0]     w_fidx;
  logic [TW-1:0]     w_ftag;
  logic [ADDR_W-1:0] w_line_addr;
  logic              w_rd_valid;
  logic [TW-1:0]     w_rd_tag;
  logic [31:0]       w_rd_data;
  logic              w_hit;
  logic              w_last;
  logic              w_beat_en;
  logic              w_set_en;

  assign w_idx       = IW'(get_idx(pc_in, OW, IW));
  assign w_off       = OW'(get_off(pc_in, OW));
  assign w_tag       = TW'(get_tag(pc_in, OW, IW, ADDR_W));
  assign w_fidx      = IW'(get_idx(32'(r_addr), OW, IW));
  assign w_ftag      = TW'(get_tag(32'(r_addr), OW, IW, ADDR_W));
  assign w_line_addr = pc_in[ADDR_W-1:0] & LINE_MASK;

  // A line is only served from IDLE; mid-refill the buffer may hold a half-written line.
  assign w_hit     = !reset && (r_state == IDLE) && w_rd_valid && (w_rd_tag == w_tag);
  assign w_last    = (r_beat == LAST_BEAT);
  assign w_beat_en = (r_state == FILL) && mem_rvalid;
  assign w_set_en  = w_beat_en && w_last && !r_flush_pend && !flush;

  ifetch_line_store #(
    .LINES (LINES),
    .WPL   (WORDS_PER_LINE),
    .IDX_W (IW),
    .OFF_W (OW),
    .TAG_W (TW)
  ) u_store (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (w_idx),
    .rd_off    (w_off),
    .rd_valid  (w_rd_valid),
    .rd_tag    (w_rd_tag),
    .rd_data   (w_rd_data),
    .wr_en     (w_beat_en),
    .wr_idx    (w_fidx),
    .wr_off    (r_beat),
    .wr_data   (mem_rdata),
    .set_en    (w_set_en),
    .set_idx   (w_fidx),
    .set_tag   (w_ftag),
    .flush_all (flush)
  );

  // Refill FSM; r_addr is the latched line address and is not part of the reset domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_flush_pend <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_hit && !flush) begin
            r_addr       <= w_line_addr;
            r_mem_addr   <= w_line_addr;
            r_mem_req    <= 1'b1;
            r_flush_pend <= 1'b0;
            r_state      <= REQ;
          end
        end
        REQ: begin
          if (flush) r_flush_pend <= 1'b1;
          if (mem_gnt) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_beat     <= '0;
            r_state    <= FILL;
          end
        end
        FILL: begin
          if (flush) r_flush_pend <= 1'b1;
          if (mem_rvalid) begin
            if (w_last) begin
              r_beat       <= '0;
              r_flush_pend <= 1'b0;
              r_state      <= IDLE;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req  = r_mem_req && !reset;
  assign mem_addr = reset ? '0 : r_mem_addr;
  assign inst_out = w_hit ? w_rd_data : 32'h0;
  assign stall    = !w_hit;

endmodule

// File: tb/tb_ifetch_responder.sv
// Directed bench for ifetch_responder: a line-level reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_ifetch_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        flush;
  logic [31:0] inst_out;
  logic        stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  ifetch_responder dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .flush      (flush),
    .inst_out   (inst_out),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what each of the 16 lines holds, plus the outstanding refill.
  bit          m_valid [16];
  logic [7:0]  m_tag   [16];
  logic [31:0] m_data  [16][4];
  bit          m_busy    = 1'b0;
  bit          m_granted = 1'b0;
  bit          m_fpend   = 1'b0;
  int          m_beats   = 0;
  logic [15:0] m_addr    = '0;

  function automatic bit m_hit(input logic [31:0] pc);
    int i;
    i = int'((pc >> 4) & 32'hF);
    return !m_busy && m_valid[i] && (m_tag[i] == pc[15:8]);
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] pc);
    return m_data[int'((pc >> 4) & 32'hF)][int'((pc >> 2) & 32'h3)];
  endfunction

  task automatic model_step();
    int li;
    if (reset) begin
      foreach (m_valid[k]) m_valid[k] = 1'b0;
      m_busy  = 1'b0;
      m_fpend = 1'b0;
    end else begin
      if (!m_busy) begin
        if (!m_hit(pc_in) && !flush) begin
          m_busy    = 1'b1;
          m_granted = 1'b0;
          m_beats   = 0;
          m_fpend   = 1'b0;
          m_addr    = pc_in[15:0] & 16'hFFF0;
        end
      end else if (!m_granted) begin
        if (flush) m_fpend = 1'b1;
        if (mem_gnt) m_granted = 1'b1;
      end else begin
        if (flush) m_fpend = 1'b1;
        if (mem_rvalid) begin
          li = int'(m_addr[7:4]);
          m_data[li][m_beats] = mem_rdata;
          m_beats++;
          if (m_beats == 4) begin
            if (!m_fpend) begin
              m_valid[li] = 1'b1;
              m_tag[li]   = m_addr[15:8];
            end
            m_busy = 1'b0;
          end
        end
      end
      if (flush) foreach (m_valid[k]) m_valid[k] = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("rst_stall", 32'(stall), 32'd1);
      chk("rst_inst", inst_out, 32'h0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'h0);
    end else begin
      chk("m_stall", 32'(stall), 32'(!m_hit(pc_in)));
      chk("m_inst", inst_out, m_hit(pc_in) ? m_word(pc_in) : 32'h0);
      chk("m_req", 32'(mem_req), 32'(m_busy && !m_granted));
      if (m_busy && !m_granted) chk("m_addr", 32'(mem_addr), 32'(m_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int lim);
    int n = 0;
    while (!mem_req && n < lim) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(mem_req), 32'd1);
  endtask

  // Runs one refill; flush_after >= 0 pulses flush right after that beat index.
  task automatic refill(input logic [15:0] exp_addr, input int gdly, input int gap,
                        input logic [31:0] w [4], input int flush_after);
    wait_req(20);
    chk("req_addr", 32'(mem_addr), 32'(exp_addr));
    for (int c = 0; c < gdly; c++) begin
      tick();
      chk("held_req", 32'(mem_req), 32'd1);
      chk("held_addr", 32'(mem_addr), 32'(exp_addr));
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int b = 0; b < 4; b++) begin
      repeat (gap) tick();
      mem_rvalid = 1'b1;
      mem_rdata  = w[b];
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      if (b == flush_after) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
    end
  endtask

  task automatic expect_hit(input string nm, input logic [31:0] pc, input logic [31:0] exp);
    pc_in = pc;
    #1;
    chk({nm, "_stall"}, 32'(stall), 32'd0);
    chk(nm, inst_out, exp);
  endtask

  logic [31:0] wl0 [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [31:0] wl2 [4] = '{32'h201, 32'h202, 32'h203, 32'h204};
  logic [31:0] wc  [4] = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
  logic [31:0] wa  [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
  logic [31:0] wb  [4] = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    pc_in      = 32'h0;
    flush      = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    tick();
    tick();
    chk("reset_stall", 32'(stall), 32'd1);
    chk("reset_req", 32'(mem_req), 32'd0);
    reset = 1'b0;

    // Cold miss on line 0
    #1;
    chk("cold_stall", 32'(stall), 32'd1);
    refill(16'h0000, 0, 0, wl0, -1);
    expect_hit("cold_w0", 32'h0, 32'h11);
    expect_hit("cold_w1", 32'h4, 32'h22);

    // Upper and byte-offset bits ignored
    expect_hit("ignored_bits", 32'hFFFF0006, 32'h22);

    // Delayed grant and gapped beats
    pc_in = 32'h20;
    refill(16'h0020, 5, 3, wl2, -1);
    expect_hit("gap_w0", 32'h20, 32'h201);
    expect_hit("gap_w3", 32'h2C, 32'h204);

    pc_in = 32'h10;
    refill(16'h0010, 0, 0, wc, -1);
    expect_hit("l10_w0", 32'h10, 32'hC0);

    // Conflicting tag replaces line 0
    pc_in = 32'h100;
    refill(16'h0100, 1, 0, wa, -1);
    expect_hit("conf_w0", 32'h100, 32'hA0);
    expect_hit("conf_w3", 32'h10C, 32'hA3);
    pc_in = 32'h0;
    #1;
    chk("conf_remiss", 32'(stall), 32'd1);

    // Flush after beat 1: fill completes but the line stays invalid
    refill(16'h0000, 0, 0, wl0, 1);
    #1;
    chk("flush_stall", 32'(stall), 32'd1);
    refill(16'h0000, 0, 0, wl0, -1);
    expect_hit("reflll_w0", 32'h0, 32'h11);
    pc_in = 32'h10;
    #1;
    chk("flush_l10_miss", 32'(stall), 32'd1);
    refill(16'h0010, 0, 0, wc, -1);
    expect_hit("l10_again", 32'h10, 32'hC0);

    // Reset mid-fill abandons the burst
    pc_in = 32'h100;
    wait_req(20);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hE0 + 32'(b);
      tick();
    end
    mem_rvalid = 1'b0;
    reset = 1'b1;
    pc_in = 32'h0;
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("postrst_req", 32'(mem_req), 32'd0);
    chk("postrst_stall", 32'(stall), 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD;
    tick();
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    refill(16'h0000, 0, 0, wb, -1);
    expect_hit("rst_w0", 32'h0, 32'hB0);
    expect_hit("rst_w3", 32'hC, 32'hB3);
    pc_in = 32'h10;
    #1;
    chk("rst_l10_miss", 32'(stall), 32'd1);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
